// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the single-clock FIFO.
//   - Default geometry and almost-empty/almost-full levels.
//   - Helpers for depth and count width, derived from the address width.
//   - A legality check on the programmable levels, used at elaboration.
//   - Encoding of the per-cycle FIFO operation: accepted write and/or read.
package sync_fifo_pkg;

  localparam int unsigned DefaultDataW    = 8;
  localparam int unsigned DefaultAddrW    = 4;
  localparam int unsigned DefaultAeLevel  = 2;
  // almost_full defaults to this many entries below full
  localparam int unsigned DefaultAfMargin = 2;

  // Operation accepted this cycle, encoded as {write, read}
  typedef enum logic [1:0] {
    OpIdle  = 2'b00,
    OpRead  = 2'b01,
    OpWrite = 2'b10,
    OpBoth  = 2'b11
  } fifo_op_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  // count spans 0..DEPTH, so it needs one bit more than the RAM address
  function automatic int unsigned count_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  function automatic int unsigned default_af_level(input int unsigned addr_w);
    return depth_of(addr_w) - DefaultAfMargin;
  endfunction

  function automatic bit levels_ok(input int unsigned depth, input int unsigned af_level,
                                   input int unsigned ae_level);
    return (ae_level < af_level) && (af_level <= depth);
  endfunction

endpackage

// File: rtl/sdp_ram_core.sv
// Single-clock simple dual-port RAM with a registered read port.
//   clk_i      clock, all activity on posedge
//   rst_i      asynchronous active-high reset of the read register only
//   wr_en_i    write strobe; wr_data_i stored at wr_addr_i
//   rd_en_i    read strobe; rd_data_o loads mem[rd_addr_i] on the next edge
//   rd_data_o  registered read data, holds its value when rd_en_i is low
// The storage array itself is never reset.
module sdp_ram_core #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned Depth = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Read-before-write on an address collision; the FIFO never reads a slot
  // that is being written in the same cycle, so no bypass is needed.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO controller around sdp_ram_core.
//   clk, rst           clock (posedge) and asynchronous active-high reset
//   wr_en, wr_data     write request; accepted only when not full
//   rd_en              read request; accepted only when not empty
//   rd_data, rd_valid  registered read word and its one-cycle valid pulse
//   full, empty        count == DEPTH / count == 0
//   almost_full/empty  count >= AF_LEVEL / count <= AE_LEVEL
//   count              occupancy 0..DEPTH
//   overflow/underflow sticky error flags, cleared by err_clr (set wins)
module sync_fifo_ctrl
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned AF_LEVEL = default_af_level(ADDR_W),
  parameter int unsigned AE_LEVEL = DefaultAeLevel
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned CntW  = count_w(ADDR_W);

  localparam logic [CntW-1:0] DepthCnt = DEPTH[CntW-1:0];
  localparam logic [CntW-1:0] AfCnt    = AF_LEVEL[CntW-1:0];
  localparam logic [CntW-1:0] AeCnt    = AE_LEVEL[CntW-1:0];
  localparam logic [CntW-1:0] One      = {{(CntW-1){1'b0}}, 1'b1};

  if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : gen_bad_levels
    $error("sync_fifo_ctrl: levels must satisfy AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  // Pointers carry a wrap bit above the RAM address
  logic [CntW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            rd_valid_q;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            wr_ok, rd_ok;
  fifo_op_e        op;

  // Flags come straight from the registered count
  always_comb begin
    full         = (count_q == DepthCnt);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfCnt);
    almost_empty = (count_q <= AeCnt);
  end

  always_comb begin
    wr_ok = wr_en && !full;
    rd_ok = rd_en && !empty;
    op    = fifo_op_e'({wr_ok, rd_ok});
  end

  always_comb begin
    wr_ptr_d    = wr_ok ? wr_ptr_q + One : wr_ptr_q;
    rd_ptr_d    = rd_ok ? rd_ptr_q + One : rd_ptr_q;
    count_d     = count_q;
    case (op)
      OpWrite: count_d = count_q + One;
      OpRead:  count_d = count_q - One;
      default: count_d = count_q;
    endcase
    // A fresh error in the same cycle as err_clr keeps the flag set
    overflow_d  = (wr_en && full)  ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
    underflow_d = (rd_en && empty) ? 1'b1 : (err_clr ? 1'b0 : underflow_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_ok;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sdp_ram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_ok),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (rd_data)
  );

  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl with a queue-based reference model.
module tb_sync_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0] count;
  logic       overflow, underflow;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model: FIFO contents as a queue plus expected output registers
  logic [7:0] mq[$];
  logic [7:0] m_rd_data = '0;
  logic       m_rd_valid = 1'b0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;

  sync_fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit m_full, m_empty, w_acc, r_acc;
    m_full  = (mq.size() == 16);
    m_empty = (mq.size() == 0);
    w_acc   = wr_en && !m_full;
    r_acc   = rd_en && !m_empty;
    if (r_acc) m_rd_data = mq.pop_front();
    m_rd_valid = r_acc;
    if (w_acc) mq.push_back(wr_data);
    if (wr_en && m_full) m_ovf = 1'b1;
    else if (err_clr) m_ovf = 1'b0;
    if (rd_en && m_empty) m_udf = 1'b1;
    else if (err_clr) m_udf = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_rd_data  = '0;
    m_rd_valid = 1'b0;
    m_ovf      = 1'b0;
    m_udf      = 1'b0;
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge
  task automatic cycle(input logic w, input logic [7:0] d, input logic r, input logic c);
    wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    @(posedge clk);
    model_step();
    #1;
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("count",        count,        mq.size());
      check("full",         full,         mq.size() == 16);
      check("empty",        empty,        mq.size() == 0);
      check("almost_full",  almost_full,  mq.size() >= 14);
      check("almost_empty", almost_empty, mq.size() <= 2);
      check("rd_data",      rd_data,      m_rd_data);
      check("rd_valid",     rd_valid,     m_rd_valid);
      check("overflow",     overflow,     m_ovf);
      check("underflow",    underflow,    m_udf);
    end
  end

  initial begin
    #2;
    check("rst count", count, 0);
    check("rst empty", empty, 1);
    check("rst full", full, 0);
    check("rst almost_empty", almost_empty, 1);
    check("rst almost_full", almost_full, 0);
    check("rst rd_data", rd_data, 0);
    check("rst rd_valid", rd_valid, 0);
    check("rst overflow", overflow, 0);
    check("rst underflow", underflow, 0);
    #10;
    rst = 1'b0;
    chk_en = 1'b1;

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 12) check("af off at 13", almost_full, 0);
      if (i == 13) check("af on at 14", almost_full, 1);
    end
    check("full after 16", full, 1);
    check("count 16", count, 16);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    check("overflow on 17th", overflow, 1);
    check("count held 16", count, 16);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      check("drain data", rd_data, i);
      check("drain valid", rd_valid, 1);
    end
    check("empty after drain", empty, 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("underflow extra read", underflow, 1);
    check("rd_data holds", rd_data, 8'h0F);
    check("rd_valid low", rd_valid, 0);

    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("err_clr ovf", overflow, 0);
    check("err_clr udf", underflow, 0);

    // Steady state at count 5 with simultaneous traffic, pointers wrap
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'(8'h30 + i), 1'b1, 1'b0);
    check("count steady 5", count, 5);
    check("last streamed word", rd_data, 8'h52);

    // Full with both requests: read oldest, write rejected
    for (int i = 0; i < 11; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    check("full again", full, 1);
    cycle(1'b1, 8'hBB, 1'b1, 1'b0);
    check("full both data", rd_data, 8'h53);
    check("full both count", count, 15);
    check("full both ovf", overflow, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf cleared", overflow, 0);

    // err_clr coincident with a new overflow: set wins
    cycle(1'b1, 8'h70, 1'b0, 1'b0);
    cycle(1'b1, 8'h71, 1'b0, 1'b1);
    check("set beats clr", overflow, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr alone", overflow, 0);

    // Empty with both requests: write accepted, read rejected
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("last before empty", rd_data, 8'h70);
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    check("empty both count", count, 1);
    check("empty both udf", underflow, 1);
    check("empty both valid", rd_valid, 0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-stream at count 9
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    check("count 9", count, 9);
    cycle(1'b1, 8'h90, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async rst count", count, 0);
    check("async rst empty", empty, 1);
    check("async rst almost_empty", almost_empty, 1);
    check("async rst rd_data", rd_data, 0);
    check("async rst rd_valid", rd_valid, 0);
    model_reset();
    rst = 1'b0;
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("post-reset data", rd_data, 8'h5A);
    check("post-reset valid", rd_valid, 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
# sync_fifo_ctrl

Parametrised single-clock FIFO built around a generalised simple dual-port RAM core. It buffers DATA_W-bit words between a producer and a consumer in the same clock domain, with occupancy count, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags. It is the same-clock companion to the team's dual-port-RAM-based FIFOs and replaces ad-hoc fixed 16x8 buffers.

## Interface
Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries (16 by default).
- AF_LEVEL, DEPTH-2 (14), almost_full asserted when count >= AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_W  write word.
- rd_en  in  1  read request.
- rd_data  out  DATA_W  read word, registered.
- rd_valid  out  1  rd_data updated this cycle by an accepted read.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.
- err_clr  in  1  synchronous clear of overflow/underflow.

## Operation
- Pointers wr_ptr, rd_ptr: ADDR_W+1 bits; low ADDR_W bits address RAM, MSB is wrap bit. Both increment modulo 2**(ADDR_W+1).
- Write accepted iff wr_en && !full: RAM[wr_ptr[ADDR_W-1:0]] <= wr_data, wr_ptr++.
- Read accepted iff rd_en && !empty: rd_data <= RAM[rd_ptr[ADDR_W-1:0]], rd_ptr++, rd_valid=1 next cycle.
- Acceptance uses flags as registered at start of cycle; full with simultaneous rd_en: read accepted, write rejected (overflow set). Empty with simultaneous wr_en: write accepted, read rejected (underflow set).
- count: +1 on write only, -1 on read only, unchanged on both or neither. Never exceeds DEPTH, never negative.
- Flags derived from registered count; full/empty/almost_* valid in the same cycle as count.
- Rejected write: no RAM update, no pointer change, overflow <= 1. Rejected read: rd_data holds, rd_valid=0, underflow <= 1.
- err_clr clears sticky flags; if a new error occurs the same cycle, set wins.
- rd_data holds last value when no read accepted.

## Timing
- Reset values: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0 (AF_LEVEL>0), rd_data=0, rd_valid=0, overflow=underflow=0. RAM contents not reset.
- Reset mid-operation: all state above cleared asynchronously; stale RAM data unreachable.
- Write latency: word written at edge N is readable by rd_en at edge N+1 (empty deasserts after edge N). No bypass path.
- Read latency: 1 cycle; rd_en accepted at edge N -> rd_data/rd_valid valid after edge N, rd_valid a single-cycle pulse per accepted read.
- Back-to-back reads/writes every cycle sustain full throughput.

## Structure
- Package sync_fifo_pkg: count-width helper (ADDR_W+1), default AF/AE level constants, parameter legality checks (AE_LEVEL < AF_LEVEL <= DEPTH).
- Sub-module sdp_ram_core: single-clock simple dual-port RAM, parameters DATA_W/ADDR_W, registered read with read enable, no reset on array.
- Top holds pointers, count, flags, error logic.

## Test plan
- Reset, then 16 writes of 0x00..0x0F -> full=1 after 16th, count=16, almost_full from 14th; 17th write (0xAA) -> overflow=1, contents unchanged.
- Drain 16 reads -> rd_data 0x00..0x0F in order, one cycle after each rd_en, rd_valid pulses; empty=1 after last; extra read -> underflow=1, rd_data holds 0x0F.
- Simultaneous rd_en/wr_en at count=5 for 40 cycles -> count stays 5, pointers wrap past 31 correctly, data order preserved.
- Full + wr_en + rd_en -> read returns oldest word, write rejected, overflow=1, count=15; empty + both -> write accepted, underflow=1, count=1.
- err_clr with no error -> flags cleared; err_clr coincident with overflow -> overflow stays 1.
- Assert rst with count=9 mid-stream -> all outputs to reset values immediately; subsequent write/read of 0x5A returns 0x5A.
